// File: rtl/lc3_pkg.sv
// lc3_pkg: shared widths and memory FSM state encoding for the LC-3 memory unit
package lc3_pkg;
  localparam int LC3_DATA_W = 16;
  localparam int LC3_ADDR_W = 16;
  localparam int LC3_WAIT_W = 4;
  typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} mem_state_e;
endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: single-port RAM, registered write, combinational read
module lc3_mem_array #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 10
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [MEM_AW-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT
);
  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  always_ff @(posedge CLK)
    if (WE) mem_q[ADDR] <= DIN;
  assign DOUT = mem_q[ADDR];
endmodule

// File: rtl/lc3_mem_unit.sv
// lc3_mem_unit: MAR/MDR plus wait-stated RAM behind a ready handshake
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int DATA_W      = LC3_DATA_W,
  parameter int ADDR_W      = LC3_ADDR_W,
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] BUS_IN,
  input  logic              LDMAR,
  input  logic              LDMDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  output logic [ADDR_W-1:0] MAR_OUT,
  output logic [DATA_W-1:0] MDR_OUT,
  output logic              R,
  output logic              BUSY
);
  mem_state_e state_q, state_d;
  logic [LC3_WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, wdata_q, wdata_d, rdata;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic rw_q, rw_d, r_q, accept, commit, we;
  always_comb begin
    accept  = state_q == MEM_IDLE && MIO_EN;
    commit  = state_q == MEM_BUSY && cnt_q == '0;
    state_d = accept ? MEM_BUSY : commit ? MEM_DONE : state_q == MEM_DONE ? MEM_IDLE : state_q;
    cnt_d   = accept ? LC3_WAIT_W'(WAIT_STATES) : (state_q == MEM_BUSY && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    mar_d   = LDMAR ? ADDR_W'(BUS_IN) : mar_q;
    // read data at commit outranks a concurrent bus load
    mdr_d   = (commit && !rw_q) ? rdata : (LDMDR && !MIO_EN) ? BUS_IN : mdr_q;
    addr_d  = accept ? mar_q[MEM_AW-1:0] : addr_q;
    wdata_d = accept ? mdr_q : wdata_q;
    rw_d    = accept ? R_W : rw_q;
    we      = commit && rw_q && !RESET;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      r_q     <= commit;
    end
  end
  lc3_mem_array #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_array (
    .CLK(CLK), .WE(we), .ADDR(addr_q), .DIN(wdata_q), .DOUT(rdata)
  );
  assign MAR_OUT = mar_q;
  assign MDR_OUT = mdr_q;
  assign R       = r_q;
  assign BUSY    = state_q != MEM_IDLE;
endmodule

// File: tb/tb_lc3_mem_unit.sv
// tb_lc3_mem_unit: directed checks of the memory unit at 2 and 0 wait states
module tb_lc3_mem_unit;
  logic clk = 1'b0, rst = 1'b1, ldmar = 1'b0, ldmdr = 1'b0, mio_en = 1'b1, r_w = 1'b0;
  logic [15:0] bus_in = '0;
  logic [15:0] mar0, mdr0, mar1, mdr1;
  logic r0, busy0, r1, busy1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lc3_mem_unit #(.WAIT_STATES(2)) dut (
    .CLK(clk), .RESET(rst), .BUS_IN(bus_in), .LDMAR(ldmar), .LDMDR(ldmdr), .MIO_EN(mio_en),
    .R_W(r_w), .MAR_OUT(mar0), .MDR_OUT(mdr0), .R(r0), .BUSY(busy0)
  );
  lc3_mem_unit #(.WAIT_STATES(0)) dut_ws0 (
    .CLK(clk), .RESET(rst), .BUS_IN(bus_in), .LDMAR(ldmar), .LDMDR(ldmdr), .MIO_EN(mio_en),
    .R_W(r_w), .MAR_OUT(mar1), .MDR_OUT(mdr1), .R(r1), .BUSY(busy1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ldmar = 1'b1; tick(); ldmar = 1'b0;
  endtask
  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; ldmdr = 1'b1; tick(); ldmdr = 1'b0;
  endtask
  // runs one access on the 2-wait-state unit; lat counts edges from accept to R
  task automatic access(input logic rw, output int lat, output logic [15:0] mdr_at_r);
    mio_en = 1'b1; r_w = rw; tick(); mio_en = 1'b0;
    lat = 0;
    mdr_at_r = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (r0) begin lat = i; mdr_at_r = mdr0; break; end
    end
    if (lat == 0) chk("access_timeout", 0, 1);
    tick();
  endtask
  initial begin
    int lat;
    logic [15:0] d;
    logic seen;
    logic [5:0] pat;
    tick(); tick();
    chk("rst_mar", mar0, 0);
    chk("rst_mdr", mdr0, 0);
    chk("rst_r", r0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_busy_ws0", busy1, 0);
    rst = 1'b0; mio_en = 1'b0;
    load_mar(16'h3005);
    chk("mar_load", mar0, 16'h3005);
    load_mdr(16'hBEEF);
    chk("mdr_load", mdr0, 16'hBEEF);
    mio_en = 1'b1; r_w = 1'b1; tick(); mio_en = 1'b0;
    chk("wr_busy_e0", busy0, 1);
    chk("wr_r_e0", r0, 0);
    tick(); chk("wr_r_e1", r0, 0);
    tick(); chk("wr_r_e2", r0, 0);
    tick(); chk("wr_r_e3", r0, 1);
    tick(); chk("wr_r_e4", r0, 0);
    chk("wr_idle_e4", busy0, 0);
    load_mdr(16'h0000);
    chk("mdr_clear", mdr0, 0);
    access(1'b0, lat, d);
    chk("rd_lat", lat, 3);
    chk("rd_data", d, 16'hBEEF);
    chk("rd_mdr_hold", mdr0, 16'hBEEF);
    load_mar(16'h0005); load_mdr(16'h1234);
    access(1'b1, lat, d);
    load_mar(16'h0405); load_mdr(16'h0000);
    access(1'b0, lat, d);
    chk("alias_rd", d, 16'h1234);
    load_mar(16'h0007); load_mdr(16'h5555);
    access(1'b1, lat, d);
    load_mar(16'h0010); load_mdr(16'hC0DE);
    mio_en = 1'b1; r_w = 1'b1; tick(); mio_en = 1'b0;
    load_mar(16'h0007);
    load_mdr(16'hAAAA);
    tick();
    chk("mid_r", r0, 1);
    chk("mid_mar", mar0, 16'h0007);
    chk("mid_mdr", mdr0, 16'hAAAA);
    tick();
    access(1'b0, lat, d);
    chk("mid_mem7", d, 16'h5555);
    load_mar(16'h0010); load_mdr(16'h0000);
    mio_en = 1'b1; r_w = 1'b0; ldmdr = 1'b1; bus_in = 16'h9999; tick();
    mio_en = 1'b0; ldmdr = 1'b0;
    chk("ldmdr_mio_noop", mdr0, 0);
    tick(); tick();
    ldmdr = 1'b1; bus_in = 16'hFFFF; tick(); ldmdr = 1'b0;
    chk("commit_r", r0, 1);
    chk("commit_mdr_wins", mdr0, 16'hC0DE);
    tick();
    chk("commit_mdr_hold", mdr0, 16'hC0DE);
    load_mar(16'h0020); load_mdr(16'h1111);
    access(1'b1, lat, d);
    load_mdr(16'h2222);
    mio_en = 1'b1; r_w = 1'b1; tick(); mio_en = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_r", r0, 0);
    chk("abort_mar", mar0, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= r0; end
    chk("abort_no_r", seen, 0);
    load_mar(16'h0020);
    access(1'b0, lat, d);
    chk("abort_mem_kept", d, 16'h1111);
    rst = 1'b1; tick(); rst = 1'b0;
    pat = '0;
    mio_en = 1'b1; r_w = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); pat = {pat[4:0], r1}; end
    mio_en = 1'b0;
    chk("ws0_held_pattern", pat, 6'b010010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lc3_mem_unit.md
# lc3_mem_unit

Parametrised memory subsystem for the LC-3 datapath: MAR, MDR and a word-addressed RAM behind a ready handshake with configurable wait states. It replaces the zero-latency MAR/MDR/RAM group hanging off the common bus. The FSM control drives MIO_EN and holds memory states until R. Data width, address width, memory depth and access latency are generics.

## Interface
- DATA_W, 16, word width of bus, MDR and RAM
- ADDR_W, 16, MAR width
- MEM_AW, 10, RAM index bits; depth 2^MEM_AW words
- WAIT_STATES, 2, extra cycles per access, range 0..15
- CLK  input  1  single clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high
- BUS_IN  input  DATA_W  common bus value
- LDMAR  input  1  load MAR from BUS_IN
- LDMDR  input  1  load MDR from BUS_IN; effective only when MIO_EN=0
- MIO_EN  input  1  memory access request, level
- R_W  input  1  1 = write, 0 = read; sampled at accept
- MAR_OUT  output  ADDR_W  MAR contents
- MDR_OUT  output  DATA_W  MDR contents, drives GateMDR tristate externally
- R  output  1  registered ready, one-cycle pulse per completed access
- BUSY  output  1  high in BUSY or DONE state

## Operation
- States: IDLE, BUSY, DONE.
- IDLE & MIO_EN=1: accept; snapshot addr = MAR[MEM_AW-1:0], wdata = MDR, rw = R_W; cnt <= WAIT_STATES; go BUSY.
- BUSY & cnt!=0: cnt <= cnt-1.
- BUSY & cnt==0: commit. Read: MDR <= mem[addr]. Write: mem[addr] <= wdata. Go DONE, R <= 1.
- DONE: R <= 0; go IDLE unconditionally. No accept in DONE.
- MIO_EN is ignored outside IDLE. Deasserting it mid-access does not cancel the access.
- MAR upper bits [ADDR_W-1:MEM_AW] are ignored, so addresses alias modulo 2^MEM_AW.
- LDMAR is honoured in any state. It does not affect an in-flight access, because the access uses the snapshot.
- LDMDR with MIO_EN=0 loads BUS_IN in any state except the commit edge of a read. On that edge the memory data wins.
- LDMDR with MIO_EN=1 is a no-op (the read result is delivered via the commit).
- LDMAR and LDMDR in the same cycle both take effect.
- Reset values: state IDLE, MAR_OUT=0, MDR_OUT=0, R=0, BUSY=0, cnt=0. RAM contents are not reset.
- RESET mid-access aborts it. A pending write is not committed, and R is not produced.

## Timing
- Accept edge is e0. Commit and R rise occur at edge e(WAIT_STATES+1). R falls at e(WAIT_STATES+2).
- MDR_OUT holds the read data in the same cycle R is high.
- WAIT_STATES=0: R is high in the cycle directly after the accept cycle.
- Minimum spacing between accepted requests is WAIT_STATES+3 edges, so a held MIO_EN re-accepts at e(WAIT_STATES+3).
- MAR_OUT/MDR_OUT update on the edge after their load strobe.

## Structure
- Shared package lc3_pkg holds:
  - mem state enum {IDLE, BUSY, DONE}
  - default width constants LC3_DATA_W=16 and LC3_ADDR_W=16
  - wait counter width constant (4 bits)
- Sub-module lc3_mem_array: single-port synchronous RAM, parameters DATA_W and MEM_AW, ports CLK, WE, ADDR, DIN, DOUT. It is registered on write and combinational on read; the read is captured into MDR at commit.
- lc3_mem_unit contains the FSM, the counter, MAR, MDR and the snapshot registers.

## Test plan
- Reset: hold RESET 2 cycles with MIO_EN=1 -> MAR_OUT=0, MDR_OUT=0, R=0, BUSY=0; no access starts while RESET is high.
- Write then read, WAIT_STATES=2:
  - Write: LDMAR with BUS_IN=0x3005, LDMDR with 0xBEEF, then MIO_EN=1 and R_W=1 -> R pulses exactly 3 edges after accept.
  - Read: reload MDR=0, then MIO_EN=1 and R_W=0 -> R pulse with MDR_OUT=0xBEEF in the same cycle.
- Aliasing, MEM_AW=10: write 0x1234 to 0x0005, then read 0x0405 -> 0x1234.
- Mid-access loads: during BUSY, LDMAR=0x0007 and LDMDR=0xAAAA -> write commits the snapshot to the original address; MAR_OUT=0x0007; mem[7] unchanged.
  - On a read's commit edge, also assert LDMDR with MIO_EN=0 -> MDR_OUT equals memory data, not BUS_IN.
- Held MIO_EN, WAIT_STATES=0: hold MIO_EN=1 for 6 cycles -> R pulses every 3 cycles, two complete accesses.
- Reset mid-write: RESET asserted at cycle 1 of BUSY -> target word keeps its old value, R never rises, state returns to IDLE.
